// File: rtl/lsu_dccm_req.sv
// LSU-side DCCM request sequencer: splits misaligned accesses, performs RMW for partial stores.
// Optional parity on stored words is enabled by defining DCCM_PARITY_EN.
//
// state | meaning
// IDLE  | ready for a new request
// RD    | array read of lo/hi words issued
// CAP   | read data sampled; load result formed or store bytes merged
// WR    | array write of lo/hi words issued
// RSP   | one-cycle completion pulse
module lsu_dccm_req #(
    parameter int DCCM_BITS        = 16,
    parameter int DCCM_BANK_BITS   = 2,
    parameter int DCCM_WIDTH_BITS  = 2,
    parameter int DCCM_FDATA_WIDTH = 39
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [1:0]                  req_size,
    input  logic                        req_unsign,
    input  logic [DCCM_BITS-1:0]        req_addr,
    input  logic [31:0]                 req_wdata,
    output logic                        rsp_valid,
    output logic [31:0]                 rsp_data,
    output logic                        rsp_err,
    output logic                        dccm_rden,
    output logic                        dccm_wren,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
    output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
    output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
    input  logic [DCCM_FDATA_WIDTH-1:0] dccm_rd_data_hi
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RSP} state_t;

    state_t state, nxt;

    logic [DCCM_BITS-1:0] lo_q, hi_q;
    logic [1:0]           size_q;
    logic                 write_q, unsign_q, mis_q;
    logic [31:0]          wdata_q;

    logic [1:0]           size_in;
    logic [2:0]           nb_m1_in;
    logic [DCCM_BITS-1:0] hi_raw, hi_sel;
    logic                 mis_in, direct_in;

    logic [5:0]  shamt;
    logic [63:0] rd_win, st_win, bm64, merged;
    logic [7:0]  nbm8, bmask8;
    logic [31:0] ld_shift, ld_res;
    logic        par_err;

    function automatic logic [3:0] par4(input logic [31:0] w);
        return {^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0]};
    endfunction

    function automatic logic [DCCM_FDATA_WIDTH-1:0] to_fdata(input logic [31:0] w);
        logic [DCCM_FDATA_WIDTH-1:0] f;
        f       = '0;
        f[31:0] = w;
`ifdef DCCM_PARITY_EN
        f[35:32] = par4(w);
`endif
        return f;
    endfunction

    // Request decode; hi wraps modulo the DCCM address space.
    always_comb begin
        size_in = (req_size == 2'd3) ? 2'd2 : req_size;
        case (size_in)
            2'd0:    nb_m1_in = 3'd0;
            2'd1:    nb_m1_in = 3'd1;
            default: nb_m1_in = 3'd3;
        endcase
        hi_raw    = req_addr + DCCM_BITS'(nb_m1_in);
        mis_in    = req_addr[DCCM_BITS-1:DCCM_WIDTH_BITS] != hi_raw[DCCM_BITS-1:DCCM_WIDTH_BITS];
        hi_sel    = mis_in ? hi_raw : req_addr;
        direct_in = req_write && (size_in == 2'd2) && (req_addr[DCCM_WIDTH_BITS-1:0] == '0);
    end

    always_comb begin
        shamt  = 6'({lo_q[DCCM_WIDTH_BITS-1:0], 3'b000});
        rd_win = {mis_q ? dccm_rd_data_hi[31:0] : dccm_rd_data_lo[31:0], dccm_rd_data_lo[31:0]};
        st_win = {32'b0, wdata_q} << shamt;
        case (size_q)
            2'd0:    nbm8 = 8'h01;
            2'd1:    nbm8 = 8'h03;
            default: nbm8 = 8'h0F;
        endcase
        bmask8 = nbm8 << lo_q[DCCM_WIDTH_BITS-1:0];
        bm64   = '0;
        for (int i = 0; i < 8; i++) begin
            bm64[8*i +: 8] = {8{bmask8[i]}};
        end
        merged   = (rd_win & ~bm64) | (st_win & bm64);
        ld_shift = 32'(rd_win >> shamt);
        case (size_q)
            2'd0:    ld_res = {{24{~unsign_q & ld_shift[7]}}, ld_shift[7:0]};
            2'd1:    ld_res = {{16{~unsign_q & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_res = ld_shift;
        endcase
`ifdef DCCM_PARITY_EN
        par_err = (par4(dccm_rd_data_lo[31:0]) != dccm_rd_data_lo[35:32]) ||
                  (mis_q && (par4(dccm_rd_data_hi[31:0]) != dccm_rd_data_hi[35:32]));
`else
        par_err = 1'b0;
`endif
    end

    // Check bits outside the parity field and the bank-select slice are consumed by the array only.
    logic unused_ok;
    assign unused_ok = ^{dccm_rd_data_lo[DCCM_FDATA_WIDTH-1:32], dccm_rd_data_hi[DCCM_FDATA_WIDTH-1:32],
                         lo_q[DCCM_WIDTH_BITS +: DCCM_BANK_BITS]};

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (req_valid) nxt = direct_in ? S_WR : S_RD;
            S_RD:    nxt = S_CAP;
            S_CAP:   nxt = (write_q && !par_err) ? S_WR : S_RSP;
            S_WR:    nxt = S_RSP;
            S_RSP:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state    <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            unsign_q <= 1'b0;
            mis_q    <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && req_valid) begin
                lo_q     <= req_addr;
                hi_q     <= hi_sel;
                size_q   <= size_in;
                write_q  <= req_write;
                unsign_q <= req_unsign;
                mis_q    <= mis_in;
                wdata_q  <= req_wdata;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            rsp_err         <= 1'b0;
            dccm_rden       <= 1'b0;
            dccm_wren       <= 1'b0;
            dccm_rd_addr_lo <= '0;
            dccm_rd_addr_hi <= '0;
            dccm_wr_addr_lo <= '0;
            dccm_wr_addr_hi <= '0;
            dccm_wr_data_lo <= '0;
            dccm_wr_data_hi <= '0;
        end else begin
            req_ready <= (nxt == S_IDLE);
            rsp_valid <= (nxt == S_RSP);
            dccm_rden <= (nxt == S_RD);
            dccm_wren <= (nxt == S_WR);
            rsp_data  <= (state == S_CAP && nxt == S_RSP && !write_q) ? ld_res : 32'b0;
            rsp_err   <= (state == S_CAP) && par_err;
            if (nxt == S_RD) begin
                dccm_rd_addr_lo <= req_addr;
                dccm_rd_addr_hi <= hi_sel;
            end
            if (nxt == S_WR) begin
                if (state == S_IDLE) begin
                    dccm_wr_addr_lo <= req_addr;
                    dccm_wr_addr_hi <= hi_sel;
                    dccm_wr_data_lo <= to_fdata(req_wdata);
                    dccm_wr_data_hi <= to_fdata(req_wdata);
                end else begin
                    dccm_wr_addr_lo <= lo_q;
                    dccm_wr_addr_hi <= hi_q;
                    dccm_wr_data_lo <= to_fdata(merged[31:0]);
                    dccm_wr_data_hi <= to_fdata(mis_q ? merged[63:32] : merged[31:0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_dccm_req.sv
// Scoreboard bench for lsu_dccm_req with a word-array DCCM model and a byte-level reference memory.
module tb_lsu_dccm_req;
    localparam int AW = 16;
    localparam int FW = 39;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          req_valid, req_ready, req_write, req_unsign;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_err;
    logic [31:0]   rsp_data;
    logic          dccm_rden, dccm_wren;
    logic [AW-1:0] dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr_lo, dccm_wr_addr_hi;
    logic [FW-1:0] dccm_wr_data_lo, dccm_wr_data_hi, dccm_rd_data_lo, dccm_rd_data_hi;

    always #5 clk = ~clk;

    lsu_dccm_req dut (
        .clk(clk), .rst_l(rst_l),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsign(req_unsign), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .dccm_rden(dccm_rden), .dccm_wren(dccm_wren),
        .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
        .dccm_wr_addr_lo(dccm_wr_addr_lo), .dccm_wr_addr_hi(dccm_wr_addr_hi),
        .dccm_wr_data_lo(dccm_wr_data_lo), .dccm_wr_data_hi(dccm_wr_data_hi),
        .dccm_rd_data_lo(dccm_rd_data_lo), .dccm_rd_data_hi(dccm_rd_data_hi)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // DCCM array model: one-cycle read latency, preload port for the stimulus thread.
    logic [FW-1:0] mem [0:16383];
    logic          pl_en = 1'b0;
    logic [13:0]   pl_idx;
    logic [FW-1:0] pl_val;

    always @(posedge clk) begin
        if (dccm_rden) begin
            dccm_rd_data_lo <= mem[dccm_rd_addr_lo[15:2]];
            dccm_rd_data_hi <= mem[dccm_rd_addr_hi[15:2]];
        end
        if (dccm_wren) begin
            mem[dccm_wr_addr_lo[15:2]] <= dccm_wr_data_lo;
            mem[dccm_wr_addr_hi[15:2]] <= dccm_wr_data_hi;
        end
        if (pl_en) mem[pl_idx] <= pl_val;
    end

    logic [7:0] ref_mem [0:65535];

    typedef struct packed {logic [31:0] data; logic err;} exp_t;
    exp_t sb_q[$];

    int rden_cnt = 0, wren_cnt = 0, overlap_cnt = 0, idle_nz_cnt = 0;
    logic [AW-1:0] last_rd_lo, last_rd_hi, last_wr_lo, last_wr_hi;
    logic [FW-1:0] last_wd_lo, last_wd_hi;

    always @(negedge clk) begin
        if (rst_l === 1'b1) begin
            exp_t e;
            if (dccm_rden && dccm_wren) overlap_cnt++;
            if (!rsp_valid && (rsp_data != 32'b0 || rsp_err)) idle_nz_cnt++;
            if (dccm_rden) begin
                rden_cnt++;
                last_rd_lo = dccm_rd_addr_lo;
                last_rd_hi = dccm_rd_addr_hi;
            end
            if (dccm_wren) begin
                wren_cnt++;
                last_wr_lo = dccm_wr_addr_lo;
                last_wr_hi = dccm_wr_addr_hi;
                last_wd_lo = dccm_wr_data_lo;
                last_wd_hi = dccm_wr_data_hi;
            end
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    function automatic logic [FW-1:0] fdata(input logic [31:0] w);
`ifdef DCCM_PARITY_EN
        return {3'b000, ^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0], w};
`else
        return {7'b0, w};
`endif
    endfunction

    task automatic preload(input logic [15:0] a, input logic [31:0] w, input logic [6:0] flip);
        pl_idx = a[15:2];
        pl_val = fdata(w) ^ {flip, 32'b0};
        pl_en  = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[16'({a[15:2], 2'b00} + i)] = w[8*i +: 8];
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [15:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] v = 32'b0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[16'(a + i)];
        if (!uns && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_store(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[16'(a + i)] = wd[8*i +: 8];
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    // Latency is counted in falling edges after the accepting rising edge.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns, input logic [15:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                          input int exp_lat, input string tag);
        int lat = 0;
        wait_ready();
        req_write = wr; req_size = sz; req_unsign = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        sb_q.push_back('{exp_d, exp_e});
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = i; break; end
        end
        check({tag, "_lat"}, lat, exp_lat);
        if (wr && !exp_e) model_store(a, (sz == 2'd3) ? 2'd2 : sz, wd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0;
        logic [1:0] sz;
        logic [15:0] a;
        logic wr, uns;
        logic [31:0] wd;
        rst_l = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsign = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_ctl", {rsp_valid, rsp_err, dccm_rden, dccm_wren}, 0);
        check("rst_addr", {dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr_lo, dccm_wr_addr_hi}, 0);
        check("rst_wdata", {dccm_wr_data_lo[31:0], dccm_wr_data_hi[31:0]}, 0);
        check("rst_rsp_data", rsp_data, 0);

        for (int w = 0; w < 'h110; w += 4) preload(16'(w), $urandom, 7'h0);

        preload(16'h0010, 32'h8765_4321, 7'h0);
        r0 = rden_cnt;
        do_req(0, 2'd2, 0, 16'h0010, 0, 32'h8765_4321, 0, 3, "ld_word");
        check("ld_word_rdaddr", {last_rd_lo, last_rd_hi}, {16'h0010, 16'h0010});
        check("ld_word_rdcnt", rden_cnt - r0, 1);

        preload(16'h0010, 32'h1100_0000, 7'h0);
        preload(16'h0014, 32'h0000_0080, 7'h0);
        do_req(0, 2'd1, 0, 16'h0013, 0, 32'hFFFF_8011, 0, 3, "ld_half_s");
        check("ld_half_rdaddr", {last_rd_lo, last_rd_hi}, {16'h0013, 16'h0014});
        do_req(0, 2'd1, 1, 16'h0013, 0, 32'h0000_8011, 0, 3, "ld_half_u");
        do_req(0, 2'd0, 0, 16'h0014, 0, 32'hFFFF_FF80, 0, 3, "ld_byte_s");
        do_req(0, 2'd3, 0, 16'h0010, 0, 32'h1100_0000, 0, 3, "ld_size3");

        preload(16'h0020, 32'h1234_5678, 7'h0);
        w0 = wren_cnt;
        do_req(1, 2'd0, 0, 16'h0022, 32'h0000_00AB, 0, 0, 4, "st_byte");
        check("st_byte_wrcnt", wren_cnt - w0, 1);
        check("st_byte_wraddr", {last_wr_lo, last_wr_hi}, {16'h0022, 16'h0022});
        check("st_byte_wdata", {last_wd_lo[31:0], last_wd_hi[31:0]}, {32'h12AB_5678, 32'h12AB_5678});
`ifdef DCCM_PARITY_EN
        check("st_byte_chk", last_wd_lo[38:32], 7'h04);
`else
        check("st_byte_chk", last_wd_lo[38:32], 7'h00);
`endif
        do_req(0, 2'd2, 0, 16'h0020, 0, 32'h12AB_5678, 0, 3, "ld_back_b");

        preload(16'h0004, 32'h0, 7'h0);
        preload(16'h0008, 32'hFFFF_FFFF, 7'h0);
        w0 = wren_cnt;
        do_req(1, 2'd2, 0, 16'h0007, 32'hDDCC_BBAA, 0, 0, 4, "st_mis");
        check("st_mis_wrcnt", wren_cnt - w0, 1);
        check("st_mis_wraddr", {last_wr_lo, last_wr_hi}, {16'h0007, 16'h000A});
        check("st_mis_wdata", {last_wd_lo[31:0], last_wd_hi[31:0]}, {32'hAA00_0000, 32'hFFDD_CCBB});

        r0 = rden_cnt; w0 = wren_cnt;
        do_req(1, 2'd2, 0, 16'h0030, 32'hCAFE_F00D, 0, 0, 2, "st_direct");
        check("st_direct_rdcnt", rden_cnt - r0, 0);
        check("st_direct_wrcnt", wren_cnt - w0, 1);
        check("st_direct_wdata", {last_wd_lo[31:0], last_wd_hi[31:0]}, {32'hCAFE_F00D, 32'hCAFE_F00D});
        do_req(0, 2'd2, 0, 16'h0030, 0, 32'hCAFE_F00D, 0, 3, "ld_back_w");

        preload(16'hFFFC, 32'hAABB_CCDD, 7'h0);
        preload(16'h0000, 32'h1122_3344, 7'h0);
        do_req(0, 2'd2, 0, 16'hFFFE, 0, 32'h3344_AABB, 0, 3, "ld_wrap");
        check("ld_wrap_rdaddr", {last_rd_lo, last_rd_hi}, {16'hFFFE, 16'h0001});

        for (int k = 0; k < 40; k++) begin
            a   = 16'($urandom_range(0, 'hF8));
            sz  = 2'($urandom_range(0, 3));
            wr  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if (wr)
                do_req(1, sz, uns, a, wd, 0, 0,
                       ((sz >= 2'd2) && (a[1:0] == 2'b00)) ? 2 : 4, "rnd_st");
            else
                do_req(0, sz, uns, a, 0, model_load(a, (sz == 2'd3) ? 2'd2 : sz, uns), 0, 3, "rnd_ld");
        end

`ifdef DCCM_PARITY_EN
        preload(16'h0040, 32'h0102_0304, 7'h01);
        w0 = wren_cnt;
        do_req(1, 2'd1, 0, 16'h0040, 32'h0000_BEEF, 0, 1, 3, "par_st");
        check("par_st_wrcnt", wren_cnt - w0, 0);
        do_req(0, 2'd2, 1, 16'h0040, 0, 32'h0102_0304, 1, 3, "par_ld");
`endif

        preload(16'h0050, 32'h5566_7788, 7'h0);
        w0 = wren_cnt;
        wait_ready();
        req_write = 1'b1; req_size = 2'd0; req_unsign = 1'b0; req_addr = 16'h0051;
        req_wdata = 32'h0000_00EE; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_in_rd", dccm_rden, 1);
        rst_l = 1'b0;
        #1;
        check("mid_rst_ctl", {rsp_valid, rsp_err, dccm_rden, dccm_wren}, 0);
        check("mid_rst_addr", {dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr_lo, dccm_wr_addr_hi}, 0);
        check("mid_rst_wdata", {dccm_wr_data_lo[31:0], dccm_wr_data_hi[31:0]}, 0);
        check("mid_rst_ready", req_ready, 1);
        @(negedge clk);
        rst_l = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_rst_no_wr", wren_cnt - w0, 0);
        check("mid_rst_ready_after", req_ready, 1);
        do_req(0, 2'd2, 0, 16'h0050, 0, 32'h5566_7788, 0, 3, "ld_after_rst");

        repeat (3) @(negedge clk);
        check("rd_wr_overlap", overlap_cnt, 0);
        check("rsp_idle_nonzero", idle_nz_cnt, 0);
        check("sb_leftover", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
